// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared types and constants for the nibble-serial adder
//   NIBBLE_W : width of one adder slice
//   state_t  : sequencer states (IDLE accept, RUN one nibble per clock, DONE present result)
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/Ripple_Carry_Adder.sv
// rtl/Ripple_Carry_Adder.sv - 4-bit ripple-carry adder slice
//   A, B : 4-bit addends
//   Cin  : carry into bit 0
//   Sum  : 4-bit sum
//   Cout : carry out of bit 3
module Ripple_Carry_Adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [4:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign Sum[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - wide adder built from one 4-bit slice, one nibble per clock
//   clk, rst_n          : clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready : request handshake; a, b, cin sampled on accept
//   a, b, cin           : operands (W = 4*NIBBLES bits) and carry-in
//   out_valid/out_ready : result handshake
//   sum, cout           : (a+b+cin) mod 2^W and carry out of the top nibble
//   ovf                 : signed overflow, only computed when OVERFLOW_FLAG_EN is defined
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic                          cin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum,
  output logic                          cout,
  output logic                          ovf
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t              state, state_nxt;
  logic [W-1:0]        a_sh, b_sh;
  logic [W-1:0]        acc, acc_nxt;
  logic [W-1:0]        sum_r;
  logic [CW-1:0]       cnt;
  logic                carry, cout_r;
  logic [NIBBLE_W-1:0] sum_nib;
  logic                c_nib;
  logic                last_run;

  Ripple_Carry_Adder u_rca (
    .A    (a_sh[NIBBLE_W-1:0]),
    .B    (b_sh[NIBBLE_W-1:0]),
    .Cin  (carry),
    .Sum  (sum_nib),
    .Cout (c_nib)
  );

  // New nibble enters at the top; after NIBBLES shifts the LSB nibble has reached bit 0.
  assign acc_nxt  = W'({sum_nib, acc} >> NIBBLE_W);
  assign last_run = (state == RUN) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> NIBBLE_W;
          b_sh  <= b_sh >> NIBBLE_W;
          acc   <= acc_nxt;
          carry <= c_nib;
          cnt   <= cnt + 1'b1;
          // Published result only changes on completion, so sum/cout hold between ops.
          if (cnt == LAST) begin
            sum_r  <= acc_nxt;
            cout_r <= c_nib;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

`ifdef OVERFLOW_FLAG_EN
  logic ovf_r;

  // On the last RUN edge the low nibble of the shift regs is the operands' top nibble,
  // so bit NIBBLE_W-1 is each operand's sign bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (last_run) begin
      ovf_r <= (a_sh[NIBBLE_W-1] == b_sh[NIBBLE_W-1]) &&
               (sum_nib[NIBBLE_W-1] != a_sh[NIBBLE_W-1]);
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

endmodule
